// File: rtl/uart_rx_param.sv
// Parametrised receive-only UART: 3-flop synchroniser, mid-bit sampling FSM,
// show-ahead receive FIFO and sticky framing/parity/overrun flags.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 712,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                rxd,
    output logic [7:0]                          rx_data,
    output logic                                rx_full,
    input  logic                                ack,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]   rx_level,
    output logic                                framing_error,
    output logic                                parity_error,
    output logic                                overrun,
    input  logic                                clear_errors
);
    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    logic [2:0]           r_sync;
    logic                 w_rxd_s;
    state_t               r_state, w_state_n;
    logic [TMR_W-1:0]     r_timer, w_timer_n;
    logic [2:0]           r_bit_cnt, w_bit_cnt_n;
    logic [DATA_BITS-1:0] r_shift, w_shift_n;
    logic                 r_par_bad, w_par_bad_n;
    logic                 w_sample, w_push, w_stop_bad;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr_n, w_rd_ptr_n;
    logic [CNT_W-1:0]     w_count, w_count_n;
    logic                 w_pop, w_full, w_wr_en, w_ovr_evt;
    logic [7:0]           w_push_data, w_head_n;
    logic [7:0]           r_rx_data;
    logic                 r_rx_full, r_ferr, r_perr, r_ovr;
    logic [LVL_W-1:0]     r_rx_level;

    // Preset to idle-high so reset never looks like a start edge
    always_ff @(posedge clock) begin
        if (reset) r_sync <= 3'b111;
        else       r_sync <= {r_sync[1:0], rxd};
    end
    assign w_rxd_s  = r_sync[2];
    assign w_sample = (r_timer == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_shift   <= w_shift_n;
            r_par_bad <= w_par_bad_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_timer_n   = r_timer;
        w_bit_cnt_n = r_bit_cnt;
        w_shift_n   = r_shift;
        w_par_bad_n = r_par_bad;
        w_push      = 1'b0;
        w_stop_bad  = 1'b0;
        if (r_state != S_IDLE && !w_sample) w_timer_n = r_timer - TMR_W'(1);
        unique case (r_state)
            S_IDLE: begin
                if (!w_rxd_s) begin
                    w_state_n   = S_START;
                    w_timer_n   = HALF_BIT;
                    w_par_bad_n = 1'b0;
                end
            end
            S_START: begin
                if (w_sample) begin
                    if (w_rxd_s) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n   = S_DATA;
                        w_timer_n   = FULL_BIT;
                        w_bit_cnt_n = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shift_n   = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                    w_timer_n   = FULL_BIT;
                    w_bit_cnt_n = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == LAST_BIT)
                        w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                // Odd parity wants XOR(data, p) = 1, even wants 0
                if (w_sample) begin
                    w_par_bad_n = (^{r_shift, w_rxd_s}) ^ (PARITY == 1);
                    w_timer_n   = FULL_BIT;
                    w_state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    if (w_rxd_s) begin
                        w_push    = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rxd_s) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign w_push_data = 8'(r_shift);
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = ack && (w_count != '0);
    assign w_wr_en     = w_push && (!w_full || w_pop);
    assign w_ovr_evt   = w_push && w_full && !w_pop;
    assign w_rd_ptr_n  = r_rd_ptr + CNT_W'(w_pop);
    assign w_wr_ptr_n  = r_wr_ptr + CNT_W'(w_wr_en);
    assign w_count_n   = w_wr_ptr_n - w_rd_ptr_n;

    // Next head: the incoming byte when it lands in the head slot, else memory
    always_comb begin
        w_head_n = '0;
        if (w_count_n != '0) begin
            if (w_wr_en && (w_rd_ptr_n[PTR_W-1:0] == r_wr_ptr[PTR_W-1:0]))
                w_head_n = w_push_data;
            else
                w_head_n = r_mem[w_rd_ptr_n[PTR_W-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_data  <= '0;
            r_rx_full  <= 1'b0;
            r_rx_level <= '0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_n;
            r_rd_ptr   <= w_rd_ptr_n;
            r_rx_data  <= w_head_n;
            r_rx_full  <= (w_count_n != '0);
            r_rx_level <= LVL_W'(w_count_n);
            r_ferr     <= (r_ferr && !clear_errors) || w_stop_bad;
            r_perr     <= (r_perr && !clear_errors) || (w_push && r_par_bad);
            r_ovr      <= (r_ovr  && !clear_errors) || w_ovr_evt;
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_full       = r_rx_full;
    assign rx_level      = r_rx_level;
    assign framing_error = r_ferr;
    assign parity_error  = r_perr;
    assign overrun       = r_ovr;
endmodule
